// File: rtl/dot_pkg.sv
// dot_pkg: shared types for the dot-product sequencing controller.
// State encodings and the FSM state enumeration.
package dot_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CLR  = ST_CLR,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/dot_ctrl_idx.sv
// dot_ctrl_idx: element counter and operand address adders.
// cnt_q is the offset of the element being fetched this cycle.
module dot_ctrl_idx
  import dot_pkg::*;
#(
  parameter int unsigned P_ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                inc_i,
  input  logic [P_ADDR_W-1:0] a_base_i,
  input  logic [P_ADDR_W-1:0] b_base_i,
  input  logic [P_ADDR_W:0]   len_i,
  output logic [P_ADDR_W-1:0] a_addr_o,
  output logic [P_ADDR_W-1:0] b_addr_o,
  output logic                len_zero_o,
  output logic                last_o,
  output logic                rd_next_o
);

  logic [P_ADDR_W-1:0] a_base_q;
  logic [P_ADDR_W-1:0] b_base_q;
  logic [P_ADDR_W:0]   len_q;
  logic [P_ADDR_W:0]   cnt_q;
  logic [P_ADDR_W:0]   cnt_d;

  // Next offset; never exceeds len+1 so it fits len's width.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
  end

  // Latch bases/len on accept, advance offset in CLR and RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_base_q <= '0;
      b_base_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      a_base_q <= a_base_i;
      b_base_q <= b_base_i;
      len_q    <= len_i;
      cnt_q    <= '0;
    end else if (inc_i) begin
      cnt_q    <= cnt_d;
    end
  end

  // Addresses wrap naturally at the memory size.
  assign a_addr_o   = a_base_q + cnt_q[P_ADDR_W-1:0];
  assign b_addr_o   = b_base_q + cnt_q[P_ADDR_W-1:0];
  assign len_zero_o = (len_q == '0);
  // In RUN, cnt_q is k+1, so k == len-1 means cnt_q == len.
  assign last_o     = (cnt_q == len_q);
  assign rd_next_o  = (cnt_d < len_q);

endmodule

// File: rtl/dot_ctrl.sv
// dot_ctrl: fetches two vectors and sequences the MAC datapath.
// Optional perf_ops handshake counter under DOT_CTRL_PERF_EN.
module dot_ctrl
  import dot_pkg::*;
#(
  parameter int unsigned P_WIDTH  = 32,
  parameter int unsigned P_ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [P_ADDR_W-1:0] a_base,
  input  logic [P_ADDR_W-1:0] b_base,
  input  logic [P_ADDR_W:0]   len,
  output logic                busy,
  output logic                mem_rd,
  output logic [P_ADDR_W-1:0] mem_a_addr,
  output logic [P_ADDR_W-1:0] mem_b_addr,
  input  logic [P_WIDTH-1:0]  mem_a_data,
  input  logic [P_WIDTH-1:0]  mem_b_data,
  output logic [P_WIDTH-1:0]  dp_a,
  output logic [P_WIDTH-1:0]  dp_b,
  output logic                dp_acc,
  input  logic [P_WIDTH-1:0]  dp_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [P_WIDTH-1:0]  res_data
`ifdef DOT_CTRL_PERF_EN
  ,
  output logic [P_WIDTH-1:0]  perf_ops
`endif
);

  state_e state_q;
  logic   busy_q;
  logic   mem_rd_q;
  logic   dp_acc_q;
  logic   res_valid_q;

  logic   accept;
  logic   step;
  logic   len_zero;
  logic   last;
  logic   rd_next;

  assign accept = (state_q == IDLE) && start;
  assign step   = (state_q == CLR) || (state_q == RUN);

  dot_ctrl_idx #(
    .P_ADDR_W (P_ADDR_W)
  ) u_idx (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .inc_i      (step),
    .a_base_i   (a_base),
    .b_base_i   (b_base),
    .len_i      (len),
    .a_addr_o   (mem_a_addr),
    .b_addr_o   (mem_b_addr),
    .len_zero_o (len_zero),
    .last_o     (last),
    .rd_next_o  (rd_next)
  );

  // Control FSM; all strobes are registered with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      dp_acc_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          dp_acc_q <= 1'b1;
          if (start) begin
            state_q  <= CLR;
            busy_q   <= 1'b1;
            dp_acc_q <= 1'b0;
            mem_rd_q <= (len != '0);
          end
        end
        CLR: begin
          dp_acc_q <= 1'b1;
          if (len_zero) begin
            state_q     <= DONE;
            mem_rd_q    <= 1'b0;
            res_valid_q <= 1'b1;
          end else begin
            state_q  <= RUN;
            mem_rd_q <= rd_next;
          end
        end
        RUN: begin
          if (last) begin
            state_q     <= DONE;
            mem_rd_q    <= 1'b0;
            res_valid_q <= 1'b1;
          end else begin
            mem_rd_q <= rd_next;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign mem_rd    = mem_rd_q;
  assign dp_acc    = dp_acc_q;
  assign res_valid = res_valid_q;
  // Read data lands in RUN; anywhere else the operands are held at 0.
  assign dp_a      = (state_q == RUN) ? mem_a_data : '0;
  assign dp_b      = (state_q == RUN) ? mem_b_data : '0;
  assign res_data  = res_valid_q ? dp_out : '0;

`ifdef DOT_CTRL_PERF_EN
  logic [P_WIDTH-1:0] perf_q;

  // Count result handshakes, wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (res_valid_q && res_ready) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_ops = perf_q;
`endif

endmodule

// File: tb/tb_dot_ctrl.sv
// tb_dot_ctrl: table vectors plus stall/reset sequences,
// with memories and a MAC datapath model around the DUT.
module tb_dot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a_base = '0;
  logic [7:0]  b_base = '0;
  logic [8:0]  len = '0;
  logic        busy;
  logic        mem_rd;
  logic [7:0]  mem_a_addr;
  logic [7:0]  mem_b_addr;
  logic [31:0] mem_a_data = '0;
  logic [31:0] mem_b_data = '0;
  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic        dp_acc;
  logic [31:0] dp_out = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
`ifdef DOT_CTRL_PERF_EN
  logic [31:0] perf_ops;
`endif

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] sb [$];
  int n_checks = 0;
  int n_err = 0;
  int n_hs = 0;

  typedef struct {
    logic [7:0]  ab;
    logic [7:0]  bb;
    logic [8:0]  ln;
    logic [31:0] ex;
  } vec_t;
  vec_t vecs [4];

  dot_ctrl #(.P_WIDTH(32), .P_ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_base     (a_base),
    .b_base     (b_base),
    .len        (len),
    .busy       (busy),
    .mem_rd     (mem_rd),
    .mem_a_addr (mem_a_addr),
    .mem_b_addr (mem_b_addr),
    .mem_a_data (mem_a_data),
    .mem_b_data (mem_b_data),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_acc     (dp_acc),
    .dp_out     (dp_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data)
`ifdef DOT_CTRL_PERF_EN
    ,
    .perf_ops   (perf_ops)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read memories, one cycle latency.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_a_data <= mem_a[mem_a_addr];
      mem_b_data <= mem_b[mem_b_addr];
    end
  end

  // MAC datapath: acc=0 clears, acc=1 adds truncated product.
  always @(posedge clk) begin
    if (!dp_acc) dp_out <= '0;
    else dp_out <= dp_out + dp_a * dp_b;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [7:0] ab,
                                        input logic [7:0] bb,
                                        input logic [8:0] ln);
    logic [31:0] s = '0;
    logic [7:0] ia, ib;
    for (int i = 0; i < int'(ln); i++) begin
      ia = ab + 8'(i);
      ib = bb + 8'(i);
      s = s + mem_a[ia] * mem_b[ib];
    end
    return s;
  endfunction

  task automatic pop_check();
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard: got %0h expected <empty queue>", res_data);
    end else begin
      check("result", res_data, sb.pop_front());
    end
  endtask

  task automatic run_vec(input logic [7:0] ab, input logic [7:0] bb,
                         input logic [8:0] ln, input logic [31:0] ex);
    int c;
    int nrd = 0;
    bit aerr = 0;
    bit got = 0;
    logic [7:0] ea, eb;
    @(negedge clk);
    start = 1'b1;
    a_base = ab;
    b_base = bb;
    len = ln;
    sb.push_back(ex);
    @(posedge clk);
    #1 start = 1'b0;
    for (c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) check("clr_acc", 32'(dp_acc), 32'd0);
      if (mem_rd) begin
        ea = ab + 8'(nrd);
        eb = bb + 8'(nrd);
        if (mem_a_addr !== ea || mem_b_addr !== eb) begin
          aerr = 1;
          $display("addr read %0d: a=%0h b=%0h", nrd, mem_a_addr, mem_b_addr);
        end
        nrd++;
      end
      if (res_valid) begin
        got = 1;
        break;
      end
    end
    check("valid_seen", 32'(got), 32'd1);
    check("latency", c, int'(ln) + 2);
    check("reads", nrd, int'(ln));
    check("addr_err", 32'(aerr), 32'd0);
    pop_check();
    if (res_ready) n_hs++;
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("valid_after", 32'(res_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    logic [31:0] held;
    logic [7:0] rab, rbb;
    logic [8:0] rln;
    bit bad;

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'(i) * 7 + 3;
      mem_b[i] = 32'(i) * 5 + 1;
    end
    for (int i = 0; i < 4; i++) begin
      mem_a[8'h10 + i] = 32'(i + 1);
      mem_b[8'h20 + i] = 32'(i + 5);
      mem_b[8'h50 + i] = 32'd1;
    end
    mem_a[8'h30] = 32'hFFFF_FFFF;
    mem_a[8'h31] = 32'd1;
    mem_b[8'h40] = 32'd2;
    mem_b[8'h41] = 32'd3;
    mem_a[8'hFE] = 32'd1;
    mem_a[8'hFF] = 32'd2;
    mem_a[8'h00] = 32'd3;
    mem_a[8'h01] = 32'd4;
    mem_a[8'h60] = 32'd3;
    mem_b[8'h70] = 32'd4;

    vecs[0] = '{8'h10, 8'h20, 9'd4, 32'd70};
    vecs[1] = '{8'h10, 8'h20, 9'd0, 32'd0};
    vecs[2] = '{8'h30, 8'h40, 9'd2, 32'd1};
    vecs[3] = '{8'hFE, 8'h50, 9'd4, 32'd10};

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd", 32'(mem_rd), 32'd0);
    check("rst_addr", {16'd0, mem_a_addr, mem_b_addr}, 32'd0);
    check("rst_ops", dp_a | dp_b, 32'd0);
    check("rst_acc", 32'(dp_acc), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_acc", 32'(dp_acc), 32'd1);

    for (int i = 0; i < 4; i++)
      run_vec(vecs[i].ab, vecs[i].bb, vecs[i].ln, vecs[i].ex);

    for (int i = 0; i < 4; i++) begin
      rab = 8'($urandom);
      rbb = 8'($urandom);
      rln = 9'($urandom_range(1, 9));
      run_vec(rab, rbb, rln, model(rab, rbb, rln));
    end
    run_vec(8'h00, 8'h00, 9'd256, model(8'h00, 8'h00, 9'd256));

    // Stall in DONE with a start pulse that must be ignored.
    res_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a_base = 8'h10;
    b_base = 8'h20;
    len = 9'd4;
    sb.push_back(32'd70);
    @(posedge clk);
    #1 start = 1'b0;
    for (c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    check("stall_lat", c, 6);
    held = res_data;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        start = 1'b1;
        a_base = 8'h30;
        b_base = 8'h40;
        len = 9'd2;
      end
      if (i == 4) start = 1'b0;
      @(negedge clk);
      if (!res_valid || res_data !== held || mem_rd) bad = 1;
    end
    check("stall_stable", 32'(bad), 32'd0);
    res_ready = 1'b1;
    pop_check();
    n_hs++;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || mem_rd || res_valid) bad = 1;
    end
    check("ignored_start", 32'(bad), 32'd0);

    // Reset in RUN at k=2, then a clean single-element run.
    @(negedge clk);
    start = 1'b1;
    a_base = 8'h10;
    b_base = 8'h20;
    len = 9'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("k2_addr", 32'(mem_a_addr), 32'h13);
    rst = 1'b0;
    #1;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_rd", 32'(mem_rd), 32'd0);
    check("ab_addr", {16'd0, mem_a_addr, mem_b_addr}, 32'd0);
    check("ab_ops", dp_a | dp_b, 32'd0);
    check("ab_acc", 32'(dp_acc), 32'd0);
    check("ab_valid", 32'(res_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || res_valid) bad = 1;
    end
    check("no_partial", 32'(bad), 32'd0);
    run_vec(8'h60, 8'h70, 9'd1, 32'd12);

`ifdef DOT_CTRL_PERF_EN
    check("perf_ops", perf_ops, 32'(n_hs));
`endif
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dot_ctrl.md
# dot_ctrl

Sequencing controller for the dot-product MAC datapath. On a start request it fetches two length-`len` operand vectors from two synchronous-read memories, one element per cycle. It gates the operands into the multiply-accumulate datapath and drives the datapath's accumulate/clear pin. It then presents the final sum on a valid/ready result port.

## Interface
- `P_WIDTH`, 32, operand/result width (matches datapath)
- `P_ADDR_W`, 8, memory address width; max vector length 2^P_ADDR_W

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  request pulse; accepted only in IDLE
- `a_base`, `b_base`  in  P_ADDR_W  vector base addresses, sampled on accept
- `len`  in  P_ADDR_W+1  element count 0..2^P_ADDR_W, sampled on accept
- `busy`  out  1  high whenever state != IDLE
- `mem_rd`  out  1  read strobe to both memories
- `mem_a_addr`, `mem_b_addr`  out  P_ADDR_W  read addresses
- `mem_a_data`, `mem_b_data`  in  P_WIDTH  read data, valid the cycle after `mem_rd`
- `dp_a`, `dp_b`  out  P_WIDTH  datapath operands; forced 0 unless an element is in flight
- `dp_acc`  out  1  datapath accumulate pin: 1 accumulates, 0 clears the accumulator
- `dp_out`  in  P_WIDTH  datapath accumulator value
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  P_WIDTH  dot-product result (equals `dp_out` while `res_valid`)

## Operation
- States: IDLE, CLR, RUN, DONE.
- IDLE: `dp_acc`=1, operands 0. `start`=1 latches bases and `len`, then goes to CLR.
- CLR, 1 cycle: `dp_acc`=0, which zeroes the accumulator.
  - If `len`>0: `mem_rd`=1 at offset 0, then RUN with element index k=0.
  - If `len`=0: no read; go to DONE.
- RUN, exactly `len` cycles: `dp_acc`=1 and `dp_a`/`dp_b` = memory data for element k.
  - If k+1<`len`: `mem_rd`=1 at base+k+1.
  - When k=`len`-1: go to DONE.
- DONE: `dp_acc`=1, operands 0, so the accumulator holds. `res_valid`=1 and `res_data`=`dp_out`.
  - `res_valid`&&`res_ready` returns to IDLE.
- Arithmetic is the datapath's: product truncated to P_WIDTH, sum wraps modulo 2^P_WIDTH. No saturation or overflow flag.
- Addresses wrap modulo 2^P_ADDR_W (base+k past top of memory wraps to 0).
- `start` while busy is ignored; it is neither queued nor an error.
- `res_ready` outside DONE has no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `mem_rd`=0, addresses 0, `dp_a`/`dp_b`=0, `dp_acc`=0 while reset asserted, `res_valid`=0.
- Start accepted at edge 0: CLR in cycle 1, RUN in cycles 2..`len`+1, `res_valid` rises in cycle `len`+2. For `len`=0, `res_valid` rises in cycle 2 with `res_data`=0.
- Memory read latency is fixed at 1 cycle; there is no backpressure on reads.
- Next `start` is accepted no earlier than the cycle after the result handshake.
- Reset asserted mid-operation aborts immediately to the reset values; no partial result is emitted.
- `res_valid` stays high and `res_data` stays stable until handshake.

## Configuration
- `DOT_CTRL_PERF_EN` defined: adds output `perf_ops` [P_WIDTH-1:0], reset 0.
  - Increments by 1 on each result handshake and wraps at 2^P_WIDTH.
- `DOT_CTRL_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `dot_pkg`: state enumeration (IDLE/CLR/RUN/DONE) and localparam state encodings.
- One sub-module, `dot_ctrl_idx`: element index counter and address adders (load on accept, increment in CLR/RUN, terminal flag at `len`-1).
- Memories and datapath are instantiated by the parent, not inside `dot_ctrl`.

## Test plan
- `len`=4, A=[1,2,3,4], B=[5,6,7,8], `res_ready`=1 → `res_valid` in cycle 6, `res_data`=70, one-cycle handshake, `busy` low in cycle 7.
- `len`=0 → no `mem_rd` pulses; `res_data`=0 with `res_valid` in cycle 2.
- `len`=2, A=[0xFFFFFFFF,1], B=[2,3], P_WIDTH=32 → `res_data`=0x00000001 (wrap).
- `res_ready` held low 10 cycles in DONE → `res_valid` and `res_data` stable; second `start` during this time is ignored.
- `a_base`=0xFE, `len`=4 → A addresses 0xFE, 0xFF, 0x00, 0x01.
- `rst` asserted in RUN at k=2 → all outputs at reset values immediately. A following run with `len`=1, A=[3], B=[4] gives 12, showing no stale accumulation.
